// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: fetch PC, single outstanding imem request,
// 2-entry instruction queue and a FETCH/FULL/DISCARD controller for redirects.
module fetch_ctrl #(
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic              iren,
    output logic [WORD_W-1:0] iaddr,
    input  logic              pred_taken,
    input  logic [WORD_W-1:0] pc_prediction,
    input  logic              misprediction,
    input  logic [WORD_W-1:0] correct_target,
    input  logic              flush,
    input  logic              freeze,
    input  logic              deq,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic              branch_pred
);

    typedef enum logic [1:0] {S_FETCH, S_FULL, S_DISCARD} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] fpc_q, fpc_d;
    logic [WORD_W-1:0] redir_q, redir_d;
    logic              req_q, req_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, wr_ptr_q;
    logic [WORD_W-1:0] instr_mem_q [2];
    logic [WORD_W-1:0] pc_mem_q    [2];
    logic              bp_mem_q    [2];

    logic redirect, do_deq, enq, clear, iren_c;

    assign redirect = flush | misprediction;
    assign do_deq   = deq && (count_q != 2'd0) && !freeze && !redirect;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        redir_d = redir_q;
        req_d   = 1'b0;
        iren_c  = 1'b0;
        enq     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // A started request is never abandoned, even under freeze.
                iren_c = req_q || ((count_q < 2'd2) && !freeze);
                if (redirect) begin
                    clear   = 1'b1;
                    redir_d = correct_target;
                    if (iren_c && !ihit) begin
                        state_d = S_DISCARD;
                    end else begin
                        fpc_d = correct_target;
                    end
                end else if (iren_c && ihit) begin
                    enq   = 1'b1;
                    fpc_d = pred_taken ? pc_prediction : fpc_q + WORD_W'(4);
                end else begin
                    req_d = iren_c;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    clear   = 1'b1;
                    fpc_d   = correct_target;
                    state_d = S_FETCH;
                end else if (do_deq) begin
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                // iaddr stays on the stale address; the redirect PC waits in redir_q.
                iren_c = 1'b1;
                clear  = redirect;
                if (redirect) redir_d = correct_target;
                if (ihit) begin
                    fpc_d   = redirect ? correct_target : redir_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({enq, do_deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        if (state_q == S_FETCH && !redirect && count_d == 2'd2) state_d = S_FULL;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_FETCH;
            fpc_q          <= RESET_PC;
            redir_q        <= RESET_PC;
            req_q          <= 1'b0;
            count_q        <= 2'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            instr_mem_q[0] <= '0;
            instr_mem_q[1] <= '0;
            pc_mem_q[0]    <= '0;
            pc_mem_q[1]    <= '0;
            bp_mem_q[0]    <= 1'b0;
            bp_mem_q[1]    <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            redir_q <= redir_d;
            req_q   <= req_d;
            count_q <= count_d;
            if (clear) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (enq) begin
                    instr_mem_q[wr_ptr_q] <= imemload;
                    pc_mem_q[wr_ptr_q]    <= fpc_q;
                    bp_mem_q[wr_ptr_q]    <= pred_taken;
                    wr_ptr_q              <= ~wr_ptr_q;
                end
                if (do_deq) rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign iren        = iren_c && !RST;
    assign iaddr       = fpc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign pc          = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign branch_pred = instr_valid && bp_mem_q[rd_ptr_q];

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC fetched first after reset.
REQ-002 Parameter WORD_W, default 32, the width of word_t, the instruction and address width.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 ihit  input  1  instruction memory completes the current request this cycle.
REQ-006 imemload  input  WORD_W  instruction data, valid when ihit=1.
REQ-007 iren  output  1  instruction memory read request.
REQ-008 iaddr  output  WORD_W  instruction memory read address.
REQ-009 pred_taken  input  1  branch predictor says taken for the address on iaddr.
REQ-010 pc_prediction  input  WORD_W  predicted target for the address on iaddr.
REQ-011 misprediction  input  1  execute-stage redirect request.
REQ-012 correct_target  input  WORD_W  redirect PC, valid with misprediction.
REQ-013 flush  input  1  pipeline flush, which discards all buffered instructions.
REQ-014 freeze  input  1  downstream stall; no dequeue and no new request start.
REQ-015 deq  input  1  decode consumes the head entry this cycle.
REQ-016 instr_valid  output  1  the head entry is valid.
REQ-017 instr  output  WORD_W  head entry instruction.
REQ-018 pc  output  WORD_W  head entry PC.
REQ-019 branch_pred  output  1  pred_taken captured with the head entry.

Function
REQ-020 The block SHALL contain a fetch PC register (fpc), a 2-entry FIFO of {instr, pc, branch_pred}, and a 3-state FSM: FETCH, FULL, DISCARD.
REQ-021 The head outputs SHALL be driven combinationally from the FIFO head; instr_valid=(count!=0).
REQ-022 At most one memory request SHALL be outstanding; iaddr=fpc; iaddr SHALL stay stable while iren=1 and ihit=0.
REQ-023 FETCH: iren=1 SHALL hold while count<2 and freeze=0, or while a request is already in progress; freeze SHALL not abort an in-progress request.
REQ-024 On ihit in FETCH with no flush or misprediction, {imemload, fpc, pred_taken} SHALL be enqueued in the same cycle.
REQ-025 On that same ihit, fpc SHALL become pc_prediction if pred_taken=1, else fpc+4, with modulo 2^WORD_W wrap.
REQ-026 If count reaches 2 after the update, the FSM SHALL enter FULL, with iren=0; it SHALL return to FETCH in the cycle after count<2.
REQ-027 Dequeue SHALL occur when deq=1, count>0 and freeze=0; deq while empty SHALL be ignored.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-029 flush or misprediction SHALL empty the FIFO on the next edge, so instr_valid=0 the following cycle.
REQ-030 On flush or misprediction, fpc SHALL load correct_target.
REQ-031 If a request is in progress and ihit=0 at a flush or misprediction, the FSM SHALL enter DISCARD: iaddr is held at the old address, and the returning data is dropped on ihit.
REQ-032 DISCARD SHALL exit on ihit, returning to FETCH; the correct_target request starts the next cycle.
REQ-033 A flush or misprediction coinciding with ihit SHALL drop the returned data, with no DISCARD entry; the new request starts next cycle.
REQ-034 A further misprediction while in DISCARD SHALL overwrite the pending redirect PC; the latest value wins.
REQ-035 flush or misprediction SHALL take priority over deq and enqueue in the same cycle.

Reset
REQ-036 While RST=1, the block SHALL hold fpc=RESET_PC, count=0, FSM=FETCH, iren=0, instr_valid=0, instr=0, pc=0 and branch_pred=0.
REQ-037 After RST deasserts, the first request SHALL issue on the first edge, with iaddr=RESET_PC.
REQ-038 RST asserted mid-request SHALL abandon the request with no DISCARD; it is memory's job to tolerate the abandoned read.

Verification
REQ-039 Sequential fetch: ihit every cycle, deq=1, imemload=0xA,0xB,0xC -> entries pc=0x0,0x4,0x8, instr_valid continuous from cycle 2.
REQ-040 Backpressure: deq=0, 3 ihits offered -> count=2, iren=0 after the second hit, fpc=0x8; one deq -> iren reasserted next cycle.
REQ-041 Predicted taken: pred_taken=1, pc_prediction=0x100 on the hit at 0x4 -> next iaddr=0x100, that entry branch_pred=1.
REQ-042 Mid-request redirect: misprediction with correct_target=0x200 while ihit=0 at iaddr=0x8 -> iaddr held 0x8 until ihit, data not enqueued, next iaddr=0x200.
REQ-043 Coincident: flush with correct_target=0x40 in the same cycle as ihit and deq -> FIFO empty next cycle, no enqueue, next iaddr=0x40.
REQ-044 Reset mid-request: RST pulse while iren=1 -> outputs zero immediately, first post-reset iaddr=RESET_PC.
